alu_cmd_sequencer: RTL and testbench

Upstream/downstream wrapper for the combinational arithmetic/logic unit. It accepts commands over a valid/ready handshake and keeps a small register file of operands. It drives registered operands and opcode into the unit, captures the unit's result into a destination register and presents it on a valid/ready result port. Commands are strictly serialised: one in flight, no hazards.

---
 rtl/alu_cmd_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Brief    : Command sequencer that wraps the combinational ALU. It holds a
//            small register file, issues one command at a time and returns
//            the result over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [5:0]       cmd_op,
  input  logic [AW-1:0]    cmd_src_a,
  input  logic [AW-1:0]    cmd_src_b,
  input  logic [AW-1:0]    cmd_dst,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_select,
  output logic             alu_c_in,
  input  logic [WIDTH-1:0] alu_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [AW-1:0]    res_dst,
  output logic             res_zero
);

  localparam int         NREG   = 2**AW;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_rf [NREG];
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [4:0]       r_alu_select;
  logic             r_alu_c_in;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic [AW-1:0]    r_res_dst;

  logic w_cmd_ready;
  logic w_accept_alu;
  logic w_accept_load;
  logic w_exec;
  logic w_release;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = cmd_load ? S_DONE : S_EXEC;
        end
      end
      S_EXEC: w_state_nxt = S_DONE;
      S_DONE: begin
        if (res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/strobe decode; ready is masked while reset is asserted
  always_comb begin
    w_cmd_ready   = (r_state == S_IDLE) && rst_n;
    w_accept_alu  = w_cmd_ready && cmd_valid && !cmd_load;
    w_accept_load = w_cmd_ready && cmd_valid && cmd_load;
    w_exec        = (r_state == S_EXEC);
    w_release     = (r_state == S_DONE) && res_ready;
  end

  // Datapath: register file, operand latches and result holding registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_select <= '0;
      r_alu_c_in   <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_dst    <= '0;
    end else begin
      if (w_accept_alu) begin
        r_alu_a                    <= r_rf[cmd_src_a];
        r_alu_b                    <= r_rf[cmd_src_b];
        {r_alu_select, r_alu_c_in} <= cmd_op;
        r_res_dst                  <= cmd_dst;
      end
      if (w_accept_load) begin
        r_rf[cmd_dst] <= cmd_imm;
        r_res_data    <= cmd_imm;
        r_res_dst     <= cmd_dst;
        r_res_valid   <= 1'b1;
      end
      // res_dst was captured at accept, so it names the write-back target
      if (w_exec) begin
        r_rf[r_res_dst] <= alu_y;
        r_res_data      <= alu_y;
        r_res_valid     <= 1'b1;
      end
      if (w_release) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign cmd_ready  = w_cmd_ready;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_select = r_alu_select;
  assign alu_c_in   = r_alu_c_in;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_dst    = r_res_dst;
  assign res_zero   = (r_res_data == '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Brief    : Scoreboard bench for alu_cmd_sequencer with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

  localparam int WIDTH = 4;
  localparam int AW    = 2;
  localparam int MOD   = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_load = 1'b0;
  logic [5:0]       cmd_op = '0;
  logic [AW-1:0]    cmd_src_a = '0;
  logic [AW-1:0]    cmd_src_b = '0;
  logic [AW-1:0]    cmd_dst = '0;
  logic [WIDTH-1:0] cmd_imm = '0;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [4:0]       alu_select;
  logic             alu_c_in;
  logic [WIDTH-1:0] alu_y;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_data;
  logic [AW-1:0]    res_dst;
  logic             res_zero;

  alu_cmd_sequencer #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
    .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_c_in(alu_c_in),
    .alu_y(alu_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_dst(res_dst), .res_zero(res_zero)
  );

  always #5 clk = ~clk;

  // Stand-in for the combinational unit
  always_comb begin
    alu_y = '0;
    case (alu_select)
      5'd0: alu_y = alu_a + WIDTH'(alu_c_in);
      5'd1: alu_y = alu_a + alu_b + WIDTH'(alu_c_in);
      5'd2: alu_y = alu_a + ~alu_b + WIDTH'(alu_c_in);
      5'd3: alu_y = alu_a & alu_b;
      5'd4: alu_y = alu_a | alu_b;
      5'd5: alu_y = alu_a ^ alu_b;
      default: alu_y = '0;
    endcase
  end

  typedef struct {
    int data;
    int dst;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   model_rf[4];
  int   exp_alu_a = 0;
  int   exp_alu_b = 0;
  int   exp_op = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic, modulo 2**WIDTH
  function automatic int ref_alu(input int sel, input int cin, input int a, input int b);
    int r;
    case (sel)
      0: r = a + cin;
      1: r = a + b + cin;
      2: r = a - b - 1 + cin;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      default: r = 0;
    endcase
    return ((r % MOD) + MOD) % MOD;
  endfunction

  task automatic issue(input bit load, input bit [5:0] op, input int sa, input int sb,
                       input int dst, input int imm);
    exp_t e;
    int   k;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_wait", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_load  = load;
    cmd_op    = op;
    cmd_src_a = AW'(sa);
    cmd_src_b = AW'(sb);
    cmd_dst   = AW'(dst);
    cmd_imm   = WIDTH'(imm);
    e.dst = dst;
    if (load) begin
      e.data        = imm % MOD;
      e.cyc         = cyc + 1;
      model_rf[dst] = imm % MOD;
    end else begin
      e.data        = ref_alu(int'(op[5:1]), int'(op[0]), model_rf[sa], model_rf[sb]);
      e.cyc         = cyc + 2;
      exp_alu_a     = model_rf[sa];
      exp_alu_b     = model_rf[sb];
      exp_op        = int'(op);
      model_rf[dst] = e.data;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_load  = 1'($urandom);
    cmd_op    = 6'($urandom);
    cmd_src_a = AW'($urandom);
    cmd_src_b = AW'($urandom);
    cmd_dst   = AW'($urandom);
    cmd_imm   = WIDTH'($urandom);
    @(negedge clk);
    chk("alu_a", int'(alu_a), exp_alu_a);
    chk("alu_b", int'(alu_b), exp_alu_b);
    chk("alu_op", int'({alu_select, alu_c_in}), exp_op);
  endtask

  // Waits for the result, holds it off for `hold` cycles, then releases it
  task automatic complete(input int hold, input bit poke);
    int k;
    k = 0;
    while (!res_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("res_valid_wait", int'(res_valid), 1);
    res_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk("cmd_ready_busy", int'(cmd_ready), 0);
      if (poke) begin
        cmd_valid = 1'b1;
        cmd_load  = 1'b1;
        cmd_dst   = '0;
        cmd_imm   = 4'd9;
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("released_valid", int'(res_valid), 0);
    chk("released_ready", int'(cmd_ready), 1);
  endtask

  // Monitor: pops on the rising result, then checks it stays stable
  bit   have = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      have = 1'b0;
    end else if (res_valid) begin
      if (!have) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", int'(res_valid), 0);
        end else begin
          cur  = sb_q.pop_front();
          have = 1'b1;
          chk("res_data", int'(res_data), cur.data);
          chk("res_dst", int'(res_dst), cur.dst);
          chk("res_zero", int'(res_zero), int'(cur.data == 0));
          chk("res_latency", cyc, cur.cyc);
        end
      end else begin
        chk("res_data_stable", int'(res_data), cur.data);
        chk("res_dst_stable", int'(res_dst), cur.dst);
      end
    end else begin
      have = 1'b0;
    end
  end

  task automatic reset_model();
    for (int i = 0; i < 4; i++) model_rf[i] = 0;
    exp_alu_a = 0;
    exp_alu_b = 0;
    exp_op    = 0;
    sb_q.delete();
  endtask

  initial begin
    reset_model();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_res_dst", int'(res_dst), 0);
    chk("rst_res_zero", int'(res_zero), 1);
    chk("rst_alu", int'({alu_a, alu_b, alu_select, alu_c_in}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", int'(cmd_ready), 1);

    // Reset during EXEC drops the command and clears the register file
    issue(1'b1, 6'b0, 0, 0, 0, 5); complete(0, 1'b0);
    issue(1'b1, 6'b0, 0, 0, 1, 3); complete(0, 1'b0);
    issue(1'b0, 6'b00001_0, 0, 1, 2, 0);
    rst_n = 1'b0;
    @(posedge clk);
    reset_model();
    @(negedge clk);
    chk("midexec_valid", int'(res_valid), 0);
    chk("midexec_ready", int'(cmd_ready), 0);
    chk("midexec_alu_a", int'(alu_a), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midexec_ready_after", int'(cmd_ready), 1);
    issue(1'b0, 6'b00000_0, 2, 2, 3, 0); complete(0, 1'b0);

    // Directed scenarios
    issue(1'b1, 6'b0, 0, 0, 0, 5); complete(0, 1'b0);
    issue(1'b1, 6'b0, 0, 0, 1, 3); complete(0, 1'b0);
    issue(1'b0, 6'b00001_0, 0, 1, 2, 0); complete(0, 1'b0);
    issue(1'b0, 6'b00000_0, 2, 0, 3, 0); complete(0, 1'b0);
    issue(1'b0, 6'b00010_1, 0, 1, 0, 0); complete(0, 1'b0);
    issue(1'b0, 6'b00000_0, 0, 0, 1, 0); complete(0, 1'b0);
    issue(1'b1, 6'b0, 0, 0, 3, 15); complete(0, 1'b0);
    issue(1'b0, 6'b00000_1, 3, 3, 2, 0); complete(1, 1'b0);
    issue(1'b1, 6'b0, 0, 0, 0, 7); complete(3, 1'b1);
    issue(1'b0, 6'b00000_0, 0, 0, 1, 0); complete(3, 1'b1);
    issue(1'b0, 6'b11111_1, 1, 2, 3, 0); complete(0, 1'b0);

    // Randomised traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        issue(1'b1, 6'($urandom), 0, 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      end else begin
        issue(1'b0, {5'($urandom_range(0, 7)), 1'($urandom)},
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 0);
      end
      complete(int'($urandom_range(0, 3)), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
